opacc_drain: RTL and testbench
==============================

OPACC_DRAIN -- requirements
Module: opacc_drain

Interface
REQ-001 Parameter nregs, default 2: number of accumulator register sets in the outer-product array.
REQ-002 Parameter vl, default 4: elements per array row.
REQ-003 Parameter XLEN, default 64: element width in bits.
REQ-004 Parameter LAT, default 3: cycles from ci_valid issue until the matching co row is valid.
REQ-005 Parameter DEPTH, default 4: output FIFO depth in rows; must be at least LAT+1.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-008 req_valid  input  1  drain request valid.
REQ-009 req_ready  output  1  drain request accepted when req_valid and req_ready are both high.
REQ-010 req_addr  input  $clog2(nregs)  accumulator set to drain.
REQ-011 req_rows  input  8  rows to drain; 0 is legal.
REQ-012 ci_valid  output  1  row-shift strobe to the array.
REQ-013 cst_addr  output  $clog2(nregs)  store address to the array.
REQ-014 cld_addr  output  $clog2(nregs)  load address to the array.
REQ-015 ci  output  vl*XLEN  load data to the array.
REQ-016 co  input  vl*XLEN  row returned by the array, valid LAT cycles after ci_valid.
REQ-017 out_valid / out_ready  output / input  1 / 1  result stream handshake.
REQ-018 out_data  output  vl*XLEN  drained row.
REQ-019 out_last  output  1  marks the final row of a request.
REQ-020 done  output  1  one-cycle pulse when a request is complete.
REQ-021 stall_cnt  output  32  credit-stall cycle count (see Configuration).

Function
REQ-022 FSM states: IDLE, ISSUE, FLUSH; req_ready is high only in IDLE.
REQ-023 IDLE, accept with req_rows>0: latch req_addr and req_rows, go to ISSUE next cycle.
REQ-024 IDLE, accept with req_rows=0: stay in IDLE, pulse done next cycle, emit no rows.
REQ-025 ISSUE: assert ci_valid with cst_addr=cld_addr=latched address and ci=0, giving read-and-clear; decrement the remaining-row count on each issue.
REQ-026 ISSUE advances to FLUSH in the cycle after the last row issues.
REQ-027 Credit rule: issue only when FIFO occupancy plus in-flight rows is less than DEPTH; the array cannot stall, so co is never dropped.
REQ-028 In-flight tracking: a LAT-deep shift register of {valid, last}; at its tail, write co with its last flag into the FIFO.
REQ-029 FIFO: first-word fall-through; out_valid = not empty.
REQ-030 FIFO pop on out_valid && out_ready; simultaneous push and pop leaves occupancy unchanged.
REQ-031 out_data and out_last must hold stable while out_valid && !out_ready.
REQ-032 FLUSH: when the in-flight count is 0 and the FIFO is empty, pulse done and return to IDLE.
REQ-033 Minimum latency: accept to first out_valid is 1+LAT cycles with out_ready held high.
REQ-034 Throughput: with out_ready held high, 1 row per cycle.

Reset
REQ-035 On reset_n low, asynchronously force: state IDLE, ci_valid 0, out_valid 0, done 0, stall_cnt 0, FIFO empty, shift register cleared.
REQ-036 Rows in flight when reset asserts mid-request are discarded.
REQ-037 cst_addr, cld_addr, ci and out_data reset to 0.
REQ-038 req_ready is high in the first cycle after reset_n deasserts.

Configuration
REQ-039 Macro OPACC_DRAIN_STALLCNT_EN defined: stall_cnt increments, saturating at 2^32-1, each ISSUE cycle blocked by the credit rule.
REQ-040 Macro OPACC_DRAIN_STALLCNT_EN undefined: stall_cnt is tied to 0 and no counter logic exists.

Verification
REQ-041 Basic drain: LAT=3, req_rows=4, addr=1, out_ready=1 -> ci_valid high 4 cycles with cst_addr=1; first out_valid 4 cycles after accept; 4 rows equal co; out_last on row 4; done pulses once.
REQ-042 Backpressure: req_rows=8, out_ready=0 -> at most 4 ci_valid issued and the array is never overrun; release out_ready -> all 8 rows delivered in order; with the macro defined, stall_cnt increases.
REQ-043 Zero rows: req_rows=0 -> no ci_valid, no out_valid, done one cycle after accept.
REQ-044 Reset mid-op: deassert reset_n 2 cycles into an 8-row drain -> all outputs 0 immediately; after release, req_ready=1 and a new 2-row request completes normally.
REQ-045 Back-to-back requests: two 3-row requests, second held on req_valid -> second accepted only after done; 6 rows total; out_last on rows 3 and 6.

Source files
------------

// File: rtl/opacc_drain_if.sv
// Request/result handshake bundle for opacc_drain.
//   req_*  : drain request channel (requester -> drain)
//   out_*  : drained row stream (drain -> consumer)
//   done   : one-cycle completion pulse (drain -> requester)
// master = requester/consumer side, slave = opacc_drain.
interface opacc_drain_if #(
  parameter int AW = 1,
  parameter int DW = 256
) ();
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_rows;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;

  modport master (
    output req_valid, req_addr, req_rows, out_ready,
    input  req_ready, out_valid, out_data, out_last, done
  );

  modport slave (
    input  req_valid, req_addr, req_rows, out_ready,
    output req_ready, out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/opacc_drain.sv
// opacc_drain: drains rows of one accumulator set out of an outer-product
// array. Each issued row is read-and-cleared (ci=0 loaded back), returns on
// co LAT cycles later and lands in a first-word-fall-through FIFO. Issue is
// credit-limited so the array, which cannot stall, never overruns the FIFO.
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   bus (slave)    req_valid/req_ready/req_addr/req_rows,
//                  out_valid/out_ready/out_data/out_last, done
//   ci_valid       row-shift strobe to the array
//   cst_addr       store address, cld_addr load address (same set)
//   ci             load data (always zero: read-and-clear)
//   co             row from the array, valid LAT cycles after ci_valid
//   stall_cnt      cycles ISSUE was blocked by credit
//
// Optional feature: define OPACC_DRAIN_STALLCNT_EN to build the saturating
// credit-stall counter; otherwise stall_cnt is tied to zero.

// Per-lane FIFO storage; pointers and control are shared from the top.
module opacc_drain_lane #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int PW    = 2
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PW-1:0]   wptr,
  input  logic [XLEN-1:0] wdata,
  input  logic [PW-1:0]   rptr,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[wptr] <= wdata;

  assign rdata = mem[rptr];
endmodule

module opacc_drain #(
  parameter  int nregs = 2,
  parameter  int vl    = 4,
  parameter  int XLEN  = 64,
  parameter  int LAT   = 3,
  parameter  int DEPTH = 4,
  localparam int AW    = (nregs > 1) ? $clog2(nregs) : 1,
  localparam int DW    = vl * XLEN
) (
  input  logic          clk,
  input  logic          reset_n,
  opacc_drain_if.slave  bus,
  output logic          ci_valid,
  output logic [AW-1:0] cst_addr,
  output logic [AW-1:0] cld_addr,
  output logic [DW-1:0] ci,
  input  logic [DW-1:0] co,
  output logic [31:0]   stall_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH + LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    rem;
  } req_t;

  state_t        state, state_n;
  req_t          req_q;
  logic          done_q, done_n;

  // In-flight tracking: stage i holds the row issued i+1 cycles ago.
  logic [LAT-1:0] vld_pipe, last_pipe;

  logic [CW-1:0]  fifo_cnt;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [DEPTH-1:0] last_mem;

  logic [SW-1:0]  inflight, occ_sum;
  logic           accept, credit_ok, issue, last_row, push, pop, empty, drained;
  logic [vl-1:0][XLEN-1:0] lane_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- control ----------------
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + SW'(vld_pipe[i]);
  end

  assign empty    = (fifo_cnt == '0);
  assign push     = vld_pipe[LAT-1];
  assign pop      = !empty && bus.out_ready;
  assign accept   = (state == IDLE) && bus.req_valid;
  // Credit counts this cycle's pop as freed space: the row being popped
  // leaves before any newly issued row can reach the FIFO.
  assign occ_sum  = SW'(fifo_cnt) + inflight - SW'(pop);
  assign credit_ok = occ_sum < SW'(DEPTH);
  assign issue    = (state == ISSUE) && credit_ok;
  assign last_row = (req_q.rem == 8'd1);
  assign drained  = (inflight == '0) && empty;

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.req_rows == 8'd0) done_n  = 1'b1;
          else                      state_n = ISSUE;
        end
      end
      ISSUE: if (issue && last_row) state_n = FLUSH;
      FLUSH: begin
        if (drained) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
      req_q  <= '0;
    end else begin
      state  <= state_n;
      done_q <= done_n;
      if (accept)     req_q <= '{addr: bus.req_addr, rem: bus.req_rows};
      else if (issue) req_q.rem <= req_q.rem - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue && last_row;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  // ---------------- FIFO ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_mem <= '0;
    end else begin
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (push) begin
        last_mem[wr_ptr] <= last_pipe[LAT-1];
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  for (genvar g = 0; g < vl; g++) begin : g_lane
    opacc_drain_lane #(.DEPTH(DEPTH), .XLEN(XLEN), .PW(PW)) u_lane (
      .clk   (clk),
      .we    (push),
      .wptr  (wr_ptr),
      .wdata (co[g*XLEN +: XLEN]),
      .rptr  (rd_ptr),
      .rdata (lane_rd[g])
    );
  end

  // ---------------- outputs ----------------
  assign bus.req_ready = (state == IDLE);
  assign bus.done      = done_q;
  assign bus.out_valid = !empty;
  // Gated by occupancy so the stream reads zero whenever nothing is queued.
  assign bus.out_data  = empty ? '0 : lane_rd;
  assign bus.out_last  = !empty && last_mem[rd_ptr];

  assign ci_valid = issue;
  assign cst_addr = req_q.addr;
  assign cld_addr = req_q.addr;
  assign ci       = '0;

`ifdef OPACC_DRAIN_STALLCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt <= '0;
    else if ((state == ISSUE) && !credit_ok && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_opacc_drain.sv
// Directed bench for opacc_drain: reset, basic drain, zero rows,
// backpressure, reset mid-drain, back-to-back held request.
`define CHK(TAG, OBS, EXP) begin n_vec++; assert ((OBS) === (EXP)) else begin n_err++; $error("FAIL %s: observed %0h expected %0h", TAG, (OBS), (EXP)); end end

module tb_opacc_drain;
  localparam int NREGS = 2, VL = 4, XLEN = 64, LAT = 3, DEPTH = 4;
  localparam int AW = 1, DW = VL * XLEN;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ci_valid;
  logic [AW-1:0] cst_addr, cld_addr;
  logic [DW-1:0] ci, co;
  logic [31:0]   stall_cnt;

  opacc_drain_if #(.AW(AW), .DW(DW)) bus ();

  opacc_drain #(.nregs(NREGS), .vl(VL), .XLEN(XLEN), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .ci_valid (ci_valid),
    .cst_addr (cst_addr),
    .cld_addr (cld_addr),
    .ci       (ci),
    .co       (co),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  function automatic logic [DW-1:0] pat(input int s);
    logic [DW-1:0] r;
    for (int l = 0; l < VL; l++) r[l*XLEN +: XLEN] = {32'hC0DE_0000 + 32'(s), 32'(l) * 32'h1111_0101};
    return r;
  endfunction

  // Array model: row pattern returns on co LAT cycles after its ci_valid.
  logic [DW-1:0] cop [LAT];
  logic [DW-1:0] ci_pat = '0;
  logic          ci_s = 1'b0;
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) cop[i] <= cop[i-1];
    cop[0] <= ci_s ? ci_pat : '0;
  end
  assign co = cop[LAT-1];

  // Monitor, sampled on the falling edge.
  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int n_issue, n_pop, n_done, bad_addr, seq, first_ov, first_pop, last_pop, max_out, hold_bad;
  logic [DW-1:0] got_d [$];
  logic [63:0]   got_l;
  logic [AW-1:0] exp_addr;
  logic          hold_prev, hold_l;
  logic [DW-1:0] hold_d;

  always @(negedge clk) begin
    ci_s = ci_valid;
    if (ci_valid) begin
      n_issue++;
      if (cst_addr !== exp_addr || cld_addr !== exp_addr || ci !== '0) bad_addr++;
      ci_pat = pat(seq);
      seq++;
    end
    if (bus.out_valid && first_ov < 0) first_ov = edge_n;
    if (bus.out_valid && bus.out_ready) begin
      got_d.push_back(bus.out_data);
      got_l = {got_l[62:0], bus.out_last};
      n_pop++;
      if (first_pop < 0) first_pop = edge_n;
      last_pop = edge_n;
    end
    if (n_issue - n_pop > max_out) max_out = n_issue - n_pop;
    if (hold_prev && (!bus.out_valid || bus.out_data !== hold_d || bus.out_last !== hold_l)) hold_bad++;
    hold_prev = bus.out_valid && !bus.out_ready;
    hold_d    = bus.out_data;
    hold_l    = bus.out_last;
    if (bus.done) n_done++;
  end

  task automatic clear();
    n_issue = 0; n_pop = 0; n_done = 0; bad_addr = 0; seq = 0;
    first_ov = -1; first_pop = -1; last_pop = -1; max_out = 0; hold_bad = 0;
    got_d.delete(); got_l = '0; hold_prev = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a request and returns the edge number at which it was accepted.
  task automatic do_req(input int a, input int r, output int acc);
    bus.req_addr  = AW'(a);
    bus.req_rows  = 8'(r);
    bus.req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin acc = edge_n + 1; break; end
    end
    if (acc < 0) `CHK("accept_timeout", bus.req_ready, 1'b1)
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int  d0;
    logic seen;
    d0 = n_done;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(posedge clk); #2;
      if (n_done != d0) seen = 1'b1;
    end
    `CHK(tag, seen, 1'b1)
  endtask

  task automatic chk_rows(input string tag, input int n, input logic [63:0] lasts);
    `CHK(tag, got_d.size(), n)
    for (int i = 0; i < n && i < got_d.size(); i++) `CHK("row_data", got_d[i], pat(i))
    `CHK("row_last", got_l, lasts)
  endtask

  initial begin
    int acc;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_rows = '0; bus.out_ready = 1'b0;
    exp_addr = '0;
    clear();

    // Reset state
    step(3);
    `CHK("rst_ci_valid", ci_valid, 1'b0)
    `CHK("rst_out_valid", bus.out_valid, 1'b0)
    `CHK("rst_done", bus.done, 1'b0)
    `CHK("rst_stall", stall_cnt, 32'd0)
    `CHK("rst_addr", cst_addr, 1'b0)
    `CHK("rst_data", bus.out_data, 256'd0)
    reset_n = 1'b1;
    @(negedge clk);
    `CHK("rdy_after_rst", bus.req_ready, 1'b1)
    step(1);

    // Basic drain: 4 rows from set 1
    bus.out_ready = 1'b1; exp_addr = 1'b1; clear();
    do_req(1, 4, acc);
    wait_done("t1_done", 60);
    step(3);
    `CHK("t1_issues", n_issue, 4)
    `CHK("t1_addr", bad_addr, 0)
    `CHK("t1_latency", first_ov - acc, LAT + 1)
    `CHK("t1_thruput", last_pop - first_pop, 3)
    chk_rows("t1_rows", 4, 64'h1);
    `CHK("t1_done_cnt", n_done, 1)
    `CHK("t1_stall", stall_cnt, 32'd0)

    // Zero rows
    clear();
    do_req(0, 0, acc);
    @(negedge clk);
    `CHK("t2_done_pulse", bus.done, 1'b1)
    `CHK("t2_ready", bus.req_ready, 1'b1)
    step(8);
    `CHK("t2_issues", n_issue, 0)
    `CHK("t2_pops", n_pop, 0)
    `CHK("t2_first_ov", first_ov, -1)
    `CHK("t2_done_cnt", n_done, 1)

    // Backpressure: 8 rows with out_ready low, then release
    bus.out_ready = 1'b0; exp_addr = 1'b0; clear();
    do_req(0, 8, acc);
    step(20);
    `CHK("t3_issues_held", n_issue, 4)
    `CHK("t3_pops_held", n_pop, 0)
    `CHK("t3_out_valid", bus.out_valid, 1'b1)
`ifdef OPACC_DRAIN_STALLCNT_EN
    `CHK("t3_stall_cnt", stall_cnt, 32'd16)
`else
    `CHK("t3_stall_cnt", stall_cnt, 32'd0)
`endif
    bus.out_ready = 1'b1;
    wait_done("t3_done", 80);
    step(3);
    `CHK("t3_issues", n_issue, 8)
    `CHK("t3_overrun", max_out <= DEPTH, 1'b1)
    `CHK("t3_hold", hold_bad, 0)
    `CHK("t3_addr", bad_addr, 0)
    chk_rows("t3_rows", 8, 64'h1);
    `CHK("t3_done_cnt", n_done, 1)

    // Reset two cycles into an 8-row drain
    exp_addr = 1'b1; clear();
    do_req(1, 8, acc);
    step(2);
    reset_n = 1'b0;
    #1;
    `CHK("t4_ci_valid", ci_valid, 1'b0)
    `CHK("t4_out_valid", bus.out_valid, 1'b0)
    `CHK("t4_done", bus.done, 1'b0)
    `CHK("t4_stall", stall_cnt, 32'd0)
    `CHK("t4_addr", cld_addr, 1'b0)
    `CHK("t4_data", bus.out_data, 256'd0)
    `CHK("t4_last", bus.out_last, 1'b0)
    step(2);
    reset_n = 1'b1;
    clear();
    @(negedge clk);
    `CHK("t4_ready", bus.req_ready, 1'b1)
    step(1);
    do_req(1, 2, acc);
    wait_done("t4_done2", 60);
    step(3);
    `CHK("t4_issues", n_issue, 2)
    chk_rows("t4_rows", 2, 64'h1);
    `CHK("t4_done_cnt", n_done, 1)

    // Back-to-back: second request held valid until the first completes
    exp_addr = 1'b1; clear();
    do_req(1, 3, acc);
    bus.req_valid = 1'b1; bus.req_addr = 1'b0; bus.req_rows = 8'd3;
    acc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = edge_n + 1;
        `CHK("t5_accept_at_done", bus.done, 1'b1)
        exp_addr = 1'b0;
        break;
      end
    end
    if (acc < 0) `CHK("t5_accept_timeout", bus.req_ready, 1'b1)
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_done("t5_done", 60);
    step(3);
    `CHK("t5_issues", n_issue, 6)
    `CHK("t5_addr", bad_addr, 0)
    chk_rows("t5_rows", 6, 64'h9);
    `CHK("t5_done_cnt", n_done, 2)

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end
endmodule
